// File: rtl/adder8.sv
// adder8: combinational adder with registered result, flags and sticky overflow.
// Optional feature: define ADDER8_SAT_EN to saturate res at all-ones on unsigned carry.
module adder8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf,
   output logic [WIDTH-1:0] res_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             ovf_sticky
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_cout;
   logic             w_ovf;
   logic             w_zero;

   logic [WIDTH-1:0] r_res;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_sticky;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_cout = w_sum[WIDTH];
   // Signed overflow: like-signed operands producing an opposite-signed sum.
   assign w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ADDER8_SAT_EN
   assign w_res = w_cout ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
   assign w_res = w_sum[WIDTH-1:0];
`endif

   assign w_zero = (w_res == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b1;
      end else if (en) begin
         r_res  <= w_res;
         r_cout <= w_cout;
         r_ovf  <= w_ovf;
         r_zero <= w_zero;
      end
   end

   // A captured overflow takes priority over a same-edge clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (en && w_ovf) begin
         r_sticky <= 1'b1;
      end else if (clr) begin
         r_sticky <= 1'b0;
      end
   end

   assign res        = w_res;
   assign cout       = w_cout;
   assign ovf        = w_ovf;
   assign res_q      = r_res;
   assign cout_q     = r_cout;
   assign ovf_q      = r_ovf;
   assign zero_q     = r_zero;
   assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_adder8.sv
// tb_adder8: vector table, hand sequences and random stimulus for adder8.
// Reference model works from integer arithmetic on the operand values.
module tb_adder8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] res;
   logic       cout;
   logic       ovf;
   logic [7:0] res_q;
   logic       cout_q;
   logic       ovf_q;
   logic       zero_q;
   logic       ovf_sticky;

   int n_cmp = 0;
   int n_bad = 0;

   int m_resq;
   int m_coutq;
   int m_ovfq;
   int m_zeroq;
   int m_sticky;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t tbl[10];

   adder8 #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr),
      .res(res), .cout(cout), .ovf(ovf),
      .res_q(res_q), .cout_q(cout_q), .ovf_q(ovf_q),
      .zero_q(zero_q), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_res(input int r, input int c);
`ifdef ADDER8_SAT_EN
      return (c != 0) ? 255 : r;
`else
      return r;
`endif
   endfunction

   function automatic void ref_add(input int x, input int y,
                                   output int r, output int c, output int o);
      int s;
      int sx;
      int sy;
      s  = x + y;
      c  = (s > 255) ? 1 : 0;
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      o  = ((sx + sy) > 127 || (sx + sy) < -128) ? 1 : 0;
      r  = sat_res(s % 256, c);
   endfunction

   task automatic model_reset();
      m_resq = 0; m_coutq = 0; m_ovfq = 0; m_zeroq = 1; m_sticky = 0;
   endtask

   task automatic chk_comb(input string tag);
      int r, c, o;
      ref_add(int'(a), int'(b), r, c, o);
      chk({tag, ".res"}, int'(res), r);
      chk({tag, ".cout"}, int'(cout), c);
      chk({tag, ".ovf"}, int'(ovf), o);
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".res_q"}, int'(res_q), m_resq);
      chk({tag, ".cout_q"}, int'(cout_q), m_coutq);
      chk({tag, ".ovf_q"}, int'(ovf_q), m_ovfq);
      chk({tag, ".zero_q"}, int'(zero_q), m_zeroq);
      chk({tag, ".sticky"}, int'(ovf_sticky), m_sticky);
   endtask

   // One clock edge: update model from inputs present at the edge, then check.
   task automatic tick(input string tag);
      int r, c, o;
      @(posedge clk);
      ref_add(int'(a), int'(b), r, c, o);
      if (rst) begin
         model_reset();
      end else begin
         if (en) begin
            m_resq = r; m_coutq = c; m_ovfq = o;
            m_zeroq = (r == 0) ? 1 : 0;
         end
         if (en && o != 0) m_sticky = 1;
         else if (clr) m_sticky = 0;
      end
      #1;
      chk_regs(tag);
   endtask

   initial begin
      int sr, sc, so, sz, ss;
      tbl[0] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
      tbl[1] = '{8'd42,  8'd0,   8'd42,  1'b0, 1'b0};
      tbl[2] = '{8'd42,  8'd1,   8'd43,  1'b0, 1'b0};
      tbl[3] = '{8'd42,  8'd32,  8'd74,  1'b0, 1'b0};
      tbl[4] = '{8'd255, 8'd32,  8'd31,  1'b1, 1'b0};
      tbl[5] = '{8'd255, 8'd1,   8'd0,   1'b1, 1'b0};
      tbl[6] = '{8'd127, 8'd1,   8'd128, 1'b0, 1'b1};
      tbl[7] = '{8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
      tbl[8] = '{8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
      tbl[9] = '{8'd128, 8'd255, 8'd127, 1'b1, 1'b1};

      // Reset held across edges with en and clr active
      model_reset();
      en = 1'b1; clr = 1'b1; a = 8'd42; b = 8'd32;
      tick("rst_hold");
      #1;
      chk_comb("rst_comb");
      @(negedge clk);
      rst = 1'b0; en = 1'b0; clr = 1'b0;

      // Vector table: combinational result, then one capture edge
      for (int i = 0; i < 10; i++) begin
         a = tbl[i].a; b = tbl[i].b; en = 1'b1;
         #1;
         chk($sformatf("tbl%0d.res", i), int'(res),
             sat_res(int'(tbl[i].res), int'(tbl[i].cout)));
         chk($sformatf("tbl%0d.cout", i), int'(cout), int'(tbl[i].cout));
         chk($sformatf("tbl%0d.ovf", i), int'(ovf), int'(tbl[i].ovf));
         tick($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.zq", i), int'(zero_q),
             (sat_res(int'(tbl[i].res), int'(tbl[i].cout)) == 0) ? 1 : 0);
      end

      // Sticky clear without capture, ovf_q held
      en = 1'b0; clr = 1'b1; a = 8'd127; b = 8'd1;
      tick("clr");
      chk("clr.sticky_lit", int'(ovf_sticky), 0);
      chk("clr.ovfq_lit", int'(ovf_q), 1);
      clr = 1'b0;

      // Overflow capture, then clear with en low
      en = 1'b1;
      tick("ovf_cap");
      chk("ovf_cap.sticky_lit", int'(ovf_sticky), 1);
      en = 1'b0; clr = 1'b1;
      tick("ovf_clr");
      chk("ovf_clr.sticky_lit", int'(ovf_sticky), 0);
      chk("ovf_clr.ovfq_lit", int'(ovf_q), 1);

      // Set wins over simultaneous clear
      en = 1'b1; clr = 1'b1;
      tick("setwins");
      chk("setwins.sticky_lit", int'(ovf_sticky), 1);
      clr = 1'b0;

      // Hold: en low, inputs change over three edges
      a = 8'd42; b = 8'd32; en = 1'b1;
      tick("load74");
      sr = m_resq; sc = m_coutq; so = m_ovfq; sz = m_zeroq; ss = m_sticky;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         tick($sformatf("hold%0d", i));
      end
      chk("hold.res_q", int'(res_q), sr);
      chk("hold.cout_q", int'(cout_q), sc);
      chk("hold.ovf_q", int'(ovf_q), so);
      chk("hold.zero_q", int'(zero_q), sz);
      chk("hold.sticky", int'(ovf_sticky), ss);

      // Asynchronous reset mid-period while res_q = 74
      a = 8'd42; b = 8'd32; en = 1'b1;
      tick("pre_arst");
      chk("pre_arst.res_q_lit", int'(res_q), 74);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst.res_q", int'(res_q), 0);
      chk("arst.zero_q", int'(zero_q), 1);
      chk("arst.sticky", int'(ovf_sticky), 0);
      chk("arst.res", int'(res), 74);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      tick("post_rst_noen");
      en = 1'b1;
      tick("first_cap");
      chk("first_cap.res_q_lit", int'(res_q), 74);

      // Randomized stimulus against the model
      for (int i = 0; i < 300; i++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         en  = 1'($urandom_range(0, 3) != 0);
         clr = 1'($urandom_range(0, 4) == 0);
         #1;
         chk_comb($sformatf("rnd%0d", i));
         tick($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adder8.md
ADDER8 -- requirements
Module: adder8

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; all width statements below use WIDTH = 8.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all registered outputs.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: a  input  8  unsigned/two's-complement operand A.
REQ-006 Port: b  input  8  unsigned/two's-complement operand B.
REQ-007 Port: en  input  1  capture enable for the registered stage.
REQ-008 Port: clr  input  1  synchronous clear of the sticky overflow flag.
REQ-009 Port: res  output  8  combinational sum.
REQ-010 Port: cout  output  1  combinational unsigned carry out.
REQ-011 Port: ovf  output  1  combinational signed overflow.
REQ-012 Port: res_q  output  8  registered sum.
REQ-013 Port: cout_q  output  1  registered carry.
REQ-014 Port: ovf_q  output  1  registered signed overflow.
REQ-015 Port: zero_q  output  1  registered flag, high when res_q = 0.
REQ-016 Port: ovf_sticky  output  1  set on any captured overflow, held until cleared.

Function
REQ-017 res SHALL equal (a + b) mod 256, zero-cycle latency, independent of clk, rst and en.
REQ-018 cout SHALL equal bit 8 of the 9-bit sum a + b.
REQ-019 ovf SHALL be 1 iff a[7] = b[7] and res[7] differs from a[7].
REQ-020 On a rising clk edge with en = 1, res_q, cout_q, ovf_q SHALL load res, cout, ovf; latency one cycle.
REQ-021 With en = 0, all registered outputs SHALL hold their values.
REQ-022 zero_q SHALL be a registered flag computed from the value loaded into res_q, so it is coherent with res_q in the same cycle.
REQ-023 ovf_sticky SHALL set on an edge where en = 1 and ovf = 1.
REQ-024 ovf_sticky SHALL clear on an edge where clr = 1.
REQ-025 Simultaneous clr = 1 and a captured overflow SHALL leave ovf_sticky = 1 (set wins).
REQ-026 Wrap-around: 255 + 1 SHALL give res = 0, cout = 1, ovf = 0.
REQ-027 Wrap-around: 127 + 1 SHALL give res = 128, cout = 0, ovf = 1.

Reset
REQ-028 While rst = 1, res_q, cout_q, ovf_q and ovf_sticky SHALL be 0 and zero_q SHALL be 1, asynchronously and regardless of clk, en and clr.
REQ-029 Reset SHALL NOT affect the combinational outputs res, cout and ovf.
REQ-030 The first capture after reset release SHALL occur on the first rising edge with rst = 0 and en = 1.

Configuration
REQ-031 With macro ADDER8_SAT_EN defined, res SHALL saturate: unsigned carry SHALL give res = 255, cout SHALL be unchanged, ovf SHALL be unchanged.
REQ-032 With ADDER8_SAT_EN undefined (default), res SHALL wrap modulo 256.
REQ-033 With ADDER8_SAT_EN defined, res_q SHALL follow the saturated res.

Verification
REQ-034 a=0,b=0 -> res=0, cout=0, ovf=0; after en edge zero_q=1.
REQ-035 a=42,b=0 -> res=42; a=42,b=1 -> res=43; a=42,b=32 -> res=74, cout=0, and after one en edge res_q=74.
REQ-036 a=255,b=32 -> res=31, cout=1, ovf=0; with ADDER8_SAT_EN defined -> res=255.
REQ-037 a=127,b=1, en=1 edge -> ovf_q=1, ovf_sticky=1; then en=0 and clr=1 edge -> ovf_sticky=0, ovf_q held at 1.
REQ-038 rst asserted mid-clock-period while res_q=74 -> res_q=0 and zero_q=1 immediately without waiting for a clk edge; res remains a+b.
REQ-039 en=0, inputs changed across 3 edges -> res_q, cout_q, ovf_q, zero_q and ovf_sticky unchanged.
